// File: rtl/wb_initiator_pkg.sv
// -----------------------------------------------------------------------------
// wb_initiator_pkg
// Shared definitions for the Wishbone classic single-transfer initiator:
// bus widths, FSM state encoding, the latched request record and a helper
// that sizes the bus-timeout counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_initiator_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    // Encodings are fixed so state values match other masters on this RAM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One request as captured from the request channel and driven on the bus.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_SEL_W-1:0]  sel;
        logic                 we;
    } wb_req_t;

    // Counter wide enough to hold TIMEOUT_CYCLES; at least one bit so a
    // disabled timeout (0) still elaborates a legal vector.
    function automatic int cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// -----------------------------------------------------------------------------
// wb_initiator_if
// Wishbone classic bus bundle between one initiator and one target.
//   adr    : byte address              (initiator -> target)
//   dat_w  : write data                (initiator -> target)
//   sel    : byte lane select          (initiator -> target)
//   cyc    : bus cycle in progress     (initiator -> target)
//   stb    : strobe / transfer valid   (initiator -> target)
//   we     : 1 = write                 (initiator -> target)
//   dat_r  : read data                 (target -> initiator)
//   ack    : transfer acknowledge      (target -> initiator)
//   err    : transfer error            (target -> initiator)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface wb_initiator_if;
    import wb_initiator_pkg::*;

    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat_w;
    logic [WB_SEL_W-1:0]  sel;
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_DATA_W-1:0] dat_r;
    logic                 ack;
    logic                 err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
// Wishbone classic single-transfer bus master. A request accepted on the
// valid/ready request channel becomes exactly one Wishbone cycle; its outcome
// (read data or error) is returned on the valid/ready response channel.
// At most one transfer is outstanding. Every output is a flop, so there is no
// combinational path from any input to any output.
//
// Parameters
//   TIMEOUT_CYCLES : cycles in BUS without ack/err before the cycle is aborted
//                    with an error; 0 disables the timeout.
//   CHECK_ALIGN    : 1 = a request with addr[1:0] != 0 is answered with an
//                    error and never reaches the bus.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_*          : request channel (valid/ready, addr, data, sel, we)
//   rsp_*          : response channel (valid/ready, data, err)
//   wbm            : Wishbone master side of wb_initiator_if
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WB_ADDR_W-1:0] req_addr,
    input  logic [WB_DATA_W-1:0] req_data,
    input  logic [WB_SEL_W-1:0]  req_sel,
    input  logic                 req_we,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DATA_W-1:0] rsp_data,
    output logic                 rsp_err,

    wb_initiator_if.master       wbm
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    // Count value seen on the edge that aborts the cycle. Unused when the
    // timeout is disabled, but kept legal so the subtraction cannot underflow.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Registered state and its next-state values.
    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    wb_req_t                bus_q,       bus_d;
    logic                   cyc_q,       cyc_d;
    logic                   stb_q,       stb_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                   rsp_err_q,   rsp_err_d;

    logic                   misaligned;
    logic                   timeout_hit;

    assign misaligned  = CHECK_ALIGN && (req_addr[1:0] != 2'b00);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a hold-value default first, so
        // no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        // Answered locally; the bus never sees this request.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = ST_RESP;
                    end else begin
                        bus_d = '{addr: req_addr, data: req_data,
                                  sel:  req_sel,  we:   req_we};
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // err beats ack beats timeout. cyc/stb drop on the same edge
                // that samples ack/err, so a target generating
                // ack = cyc & stb & !ack never sees a second strobe.
                if (wbm.err) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RESP;
                end else if (wbm.ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = bus_q.we ? '0 : wbm.dat_r;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: return to a clean idle bus.
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. Reset is asynchronous so cyc/stb drop the moment rst_n
    // falls, and any pending response is discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_q       <= bus_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs straight from flops
    // -------------------------------------------------------------------------
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    assign wbm.adr   = bus_q.addr;
    assign wbm.dat_w = bus_q.data;
    assign wbm.sel   = bus_q.sel;
    assign wbm.we    = bus_q.we;
    assign wbm.cyc   = cyc_q;
    assign wbm.stb   = stb_q;

endmodule

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    typedef enum logic [1:0] {SL_ACK, SL_ERR, SL_BOTH, SL_NONE} slave_mode_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        slave_mode_t mode;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_cyc;
        int          exp_ack;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_sel = '0;
    logic        req_we = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;

    wb_initiator_if bus ();

    wb_initiator #(.TIMEOUT_CYCLES(8), .CHECK_ALIGN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .req_we    (req_we),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wbm       (bus)
    );

    always #5 clk = ~clk;

    // ---------------- RAM-like target with 1-cycle registered ack ----------
    slave_mode_t mode = SL_ACK;
    logic        inj_ack = 1'b0;
    logic        ack_q, err_q;
    logic [31:0] rdat_q;
    logic [31:0] mem [64];

    assign bus.ack   = ack_q | inj_ack;
    assign bus.err   = err_q;
    assign bus.dat_r = rdat_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (bus.cyc && bus.stb && !ack_q && !err_q) begin
                case (mode)
                    SL_ACK: begin
                        ack_q  <= 1'b1;
                        rdat_q <= mem[bus.adr[7:2]];
                        if (bus.we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (bus.sel[b]) mem[bus.adr[7:2]][8*b +: 8] <= bus.dat_w[8*b +: 8];
                            end
                        end
                    end
                    SL_ERR: begin
                        err_q  <= 1'b1;
                        rdat_q <= mem[bus.adr[7:2]];
                    end
                    SL_BOTH: begin
                        ack_q  <= 1'b1;
                        err_q  <= 1'b1;
                        rdat_q <= mem[bus.adr[7:2]];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- bus monitor ------------------------------------------
    logic cnt_clr = 1'b0;
    int   cyc_cnt = 0;
    int   ack_cnt = 0;

    always @(posedge clk) begin
        if (cnt_clr) begin
            cyc_cnt <= 0;
            ack_cnt <= 0;
        end else begin
            if (bus.cyc)           cyc_cnt <= cyc_cnt + 1;
            if (bus.cyc && bus.ack) ack_cnt <= ack_cnt + 1;
        end
    end

    // ---------------- checking helpers -------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    // Presents one request and returns on the negedge after it was accepted.
    task automatic issue_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] sel);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        req_sel   = sel;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid; samples data/err on a negedge.
    task automatic wait_rsp(output logic got, output logic err, output logic [31:0] data);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got  = rsp_valid;
        err  = rsp_err;
        data = rsp_data;
        if (!got) check("rsp_valid_wait", 32'(got), 32'd1);
    endtask

    // Full transfer with rsp_ready=1; returns back in IDLE.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, output logic err, output logic [31:0] rdata);
        logic got;
        clear_counts();
        issue_req(we, addr, data, sel);
        wait_rsp(got, err, rdata);
        @(negedge clk);
    endtask

    vec_t        vecs [10];
    logic        r_err;
    logic [31:0] r_data;
    logic        r_got;

    initial begin
        //            we    addr          data          sel      mode     err   data          cyc ack
        vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, SL_ACK,  1'b0, 32'h0000_0000, 2, 1};
        vecs[1] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'b1111, SL_ACK,  1'b0, 32'hDEAD_BEEF, 2, 1};
        vecs[2] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, SL_ACK,  1'b0, 32'h0000_0000, 2, 1};
        vecs[3] = '{1'b1, 32'h8000_0020, 32'h0000_AB00, 4'b0010, SL_ACK,  1'b0, 32'h0000_0000, 2, 1};
        vecs[4] = '{1'b0, 32'h8000_0020, 32'h0000_0000, 4'b1111, SL_ACK,  1'b0, 32'h1122_AB44, 2, 1};
        vecs[5] = '{1'b0, 32'h8000_0002, 32'h0000_0000, 4'b1111, SL_ACK,  1'b1, 32'h0000_0000, 0, 0};
        vecs[6] = '{1'b1, 32'h8000_0013, 32'hFFFF_FFFF, 4'b1111, SL_ACK,  1'b1, 32'h0000_0000, 0, 0};
        vecs[7] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'b1111, SL_ERR,  1'b1, 32'h0000_0000, 2, 0};
        vecs[8] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'b1111, SL_BOTH, 1'b1, 32'h0000_0000, 2, 1};
        vecs[9] = '{1'b0, 32'h8000_0024, 32'h0000_0000, 4'b1111, SL_ACK,  1'b0, 32'h0000_0000, 2, 1};

        // ---------------- reset state ----------------
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp", {rsp_data[29:0], rsp_valid, rsp_err}, 32'd0);
        check("rst_wb_ctl", {27'd0, bus.cyc, bus.stb, bus.we, 2'b00}, 32'd0);
        check("rst_wb_adr", bus.adr | bus.dat_w | 32'(bus.sel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // ---------------- table-driven transfers ----------------
        // Word 9 (0x80000024) is written zero before its read-back vector.
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                mode = SL_ACK;
                txn(1'b1, 32'h8000_0024, 32'h0, 4'b1111, r_err, r_data);
            end
            mode = vecs[i].mode;
            txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, r_err, r_data);
            check($sformatf("v%0d_err", i),  32'(r_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_data", i), r_data, vecs[i].exp_data);
            check($sformatf("v%0d_cyc_cycles", i), 32'(cyc_cnt), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_acks", i), 32'(ack_cnt), 32'(vecs[i].exp_ack));
        end
        mode = SL_ACK;

        // ---------------- timeout then late ack in IDLE ----------------
        mode = SL_NONE;
        txn(1'b0, 32'h8000_0030, 32'h0, 4'b1111, r_err, r_data);
        check("tmo_err", 32'(r_err), 32'd1);
        check("tmo_data", r_data, 32'd0);
        check("tmo_cyc_cycles", 32'(cyc_cnt), 32'd8);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_idle", {29'd0, rsp_valid, req_ready, bus.cyc}, 32'b010);
            @(negedge clk);
        end
        mode = SL_ACK;

        // ---------------- response back-pressure ----------------
        rsp_ready = 1'b0;
        clear_counts();
        issue_req(1'b0, 32'h8000_0010, 32'h0, 4'b1111);
        wait_rsp(r_got, r_err, r_data);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_ready", {30'd0, rsp_valid, req_ready}, 32'b10);
            check("stall_data", rsp_data, 32'hDEAD_BEEF);
            check("stall_err", 32'(rsp_err), 32'd0);
            @(negedge clk);
        end
        check("stall_single_ack", 32'(ack_cnt), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {30'd0, rsp_valid, req_ready}, 32'b01);

        // ---------------- async reset during BUS ----------------
        mode = SL_NONE;
        issue_req(1'b0, 32'h8000_0010, 32'h0, 4'b1111);
        @(posedge clk);
        check("bus_cyc_before_rst", 32'(bus.cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc_stb", {30'd0, bus.cyc, bus.stb}, 32'd0);
        check("async_rst_ready_valid", {30'd0, req_ready, rsp_valid}, 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
        mode = SL_ACK;
        txn(1'b0, 32'h8000_0010, 32'h0, 4'b1111, r_err, r_data);
        check("post_rst_read_err", 32'(r_err), 32'd0);
        check("post_rst_read_data", r_data, 32'hDEAD_BEEF);
        check("post_rst_read_acks", 32'(ack_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
